ref_fetch: RTL and testbench
============================

REF_FETCH -- requirements
Module: ref_fetch

Interface
REQ-001 Parameter FRAME_W, default 1920: reference frame row pitch in bytes.
REQ-002 Parameter WIN_W, default 48: search-window width in bytes; SHALL be a multiple of 8, max 2040.
REQ-003 Parameter WIN_H, default 48: search-window height in rows, max 255.
REQ-004 Parameter BASE_ADDR, default 0: byte address of frame pixel (0,0).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle request to fetch a window; sampled only in IDLE.
REQ-008 win_x  in  16  window left column in bytes, multiple of 8; sampled with start.
REQ-009 win_y  in  16  window top row; sampled with start.
REQ-010 busy  out  1  high from the cycle after an accepted start until done.
REQ-011 done  out  1  one-cycle pulse after the last word is accepted downstream.
REQ-012 mem_en  out  1  read enable to the reference memory (combinational read, data valid in the same cycle).
REQ-013 mem_addr  out  32  byte address of the 8-byte word being read.
REQ-014 mem_data  in  64  read data, byte at mem_addr in [63:56].
REQ-015 out_valid  out  1  out_data holds a valid word.
REQ-016 out_ready  in  1  downstream accepts the word when out_valid & out_ready.
REQ-017 out_data  out  64  8 reference pixels, unchanged byte order.
REQ-018 out_row  out  8  window row index of out_data.
REQ-019 out_col  out  8  word index within the row (0 .. WIN_W/8-1).
REQ-020 out_last  out  1  high with the final word of the window.

Function
REQ-021 FSM states IDLE, FETCH, DRAIN; IDLE->FETCH on start, FETCH->DRAIN when the last read is issued, DRAIN->IDLE when the FIFO is empty and the last word has been accepted.
REQ-022 In FETCH, a read SHALL be issued (mem_en=1) in every cycle the 2-entry output FIFO is not full after the current cycle's pop; mem_data is written into the FIFO at the end of that cycle.
REQ-023 mem_addr = BASE_ADDR + (win_y+row)*FRAME_W + win_x + 8*col, computed in 32 bits, wrapping modulo 2^32.
REQ-024 Read order is raster: col increments first, row increments on col wrap from WIN_W/8-1 to 0; total reads = WIN_H*WIN_W/8.
REQ-025 mem_en=0 and mem_addr=0 in every cycle no read is issued.
REQ-026 out_* SHALL reflect the FIFO head; out_data/out_row/out_col/out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-027 Simultaneous push and pop on a full FIFO SHALL be permitted (throughput one word/cycle with out_ready held high).
REQ-028 First word reaches out_valid one cycle after start is accepted into FETCH (two cycles after start).
REQ-029 start asserted while busy SHALL be ignored with no effect on the current fetch.
REQ-030 done SHALL pulse in the cycle after the transfer with out_last=1; busy falls in that same cycle.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, empty FIFO, counters to 0, and all outputs to 0, including mid-fetch; no residual word is delivered after release.

Structure
REQ-032 Shared package me_pkg holds the FSM state encoding and the address/pixel-word widths (ADDR_W=32, WORD_W=64).
REQ-033 One sub-module, ref_fifo2 (2-entry FIFO storing {last,row,col,data}), is natural; the address generator and FSM stay in ref_fetch.

Verification
REQ-034 WIN_W=16, WIN_H=2, FRAME_W=64, BASE_ADDR=0, start with win_x=8, win_y=3, out_ready=1 -> mem_addr sequence 200,208,264,272; 4 words; out_last on 4th; done one cycle later.
REQ-035 Same setup, out_ready low for 5 cycles after the first valid -> mem_en drops after 2 reads, out_data of word 0 is held, no word lost or duplicated.
REQ-036 Default parameters, out_ready=1 -> 288 words on consecutive cycles, done at cycle 290 after start.
REQ-037 start pulsed again at word 2 of a fetch -> ignored; address sequence and word count unchanged.
REQ-038 rst_n asserted at word 3 of 4 -> all outputs 0 immediately; after release, no out_valid until a new start.
REQ-039 win_y=0xFFFF with BASE_ADDR=0xFFFFFF00 -> addresses wrap modulo 2^32 exactly per REQ-023 formula.

Source files
------------

// File: rtl/me_pkg.sv
// Shared types for the motion-estimation reference fetch path.
package me_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 64;
    localparam int unsigned IDX_W  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } fetch_state_e;

    typedef struct packed {
        logic              last;
        logic [IDX_W-1:0]  row;
        logic [IDX_W-1:0]  col;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/ref_fifo2.sv
// Two-entry output FIFO; full-FIFO push+pop in one cycle keeps one word/cycle.
module ref_fifo2
    import me_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  fifo_entry_t wdata_i,
    input  logic        pop_i,
    output logic [1:0]  count_o,
    output logic        valid_o,
    output fifo_entry_t rdata_o
);

    fifo_entry_t mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        pop;

    assign pop     = pop_i && (count_q != 2'd0);
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;
    // Empty FIFO presents zeros so stale words never leak onto the outputs.
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push_i && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ref_fetch.sv
// Fetches a WIN_W x WIN_H search window from reference memory in raster order
// and streams it out through a 2-entry FIFO with valid/ready handshake.
module ref_fetch
    import me_pkg::*;
#(
    parameter int unsigned       FRAME_W   = 1920,
    parameter int unsigned       WIN_W     = 48,
    parameter int unsigned       WIN_H     = 48,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [15:0]       win_x_i,
    input  logic [15:0]       win_y_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [WORD_W-1:0] mem_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WORD_W-1:0] out_data_o,
    output logic [IDX_W-1:0]  out_row_o,
    output logic [IDX_W-1:0]  out_col_o,
    output logic              out_last_o
);

    localparam int unsigned      COLS     = WIN_W / 8;
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(WIN_H - 1);

    fetch_state_e     state_q, state_d;
    logic [15:0]      win_x_q, win_x_d;
    logic [15:0]      win_y_q, win_y_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic             done_q, done_d;

    logic              issue;
    logic              pop;
    logic              last_rd;
    logic [1:0]        fifo_count;
    logic [ADDR_W-1:0] addr_calc;
    fifo_entry_t       push_entry;
    fifo_entry_t       head;

    assign pop     = out_valid_o && out_ready_i;
    assign last_rd = (row_q == LAST_ROW) && (col_q == LAST_COL);

    // All terms widened to 32 bits first so the sum wraps modulo 2^32.
    assign addr_calc = BASE_ADDR
                     + (ADDR_W'(win_y_q) + ADDR_W'(row_q)) * ADDR_W'(FRAME_W)
                     + ADDR_W'(win_x_q)
                     + {{(ADDR_W - IDX_W - 3){1'b0}}, col_q, 3'b000};

    always_comb begin
        state_d = state_q;
        win_x_d = win_x_q;
        win_y_d = win_y_q;
        row_d   = row_q;
        col_d   = col_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                    win_x_d = win_x_i;
                    win_y_d = win_y_i;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StFetch: begin
                // Read whenever the FIFO has room once this cycle's pop is counted.
                if ((fifo_count != 2'd2) || pop) begin
                    issue = 1'b1;
                    if (last_rd) begin
                        state_d = StDrain;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + IDX_W'(1);
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end
            end
            StDrain: begin
                if (pop && head.last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            win_x_q <= '0;
            win_y_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_x_q <= win_x_d;
            win_y_q <= win_y_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
        end
    end

    assign push_entry.last = last_rd;
    assign push_entry.row  = row_q;
    assign push_entry.col  = col_q;
    assign push_entry.data = mem_data_i;

    ref_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (issue),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .count_o (fifo_count),
        .valid_o (out_valid_o),
        .rdata_o (head)
    );

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign mem_en_o    = issue;
    assign mem_addr_o  = issue ? addr_calc : '0;
    assign out_data_o  = head.data;
    assign out_row_o   = head.row;
    assign out_col_o   = head.col;
    assign out_last_o  = head.last;

endmodule

// File: tb/tb_ref_fetch.sv
// Directed bench for ref_fetch: small 16x2 window and a default-size wrapping window.
module tb_ref_fetch;
    import me_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {a, ~a};
    endfunction

    // Small instance: WIN_W=16, WIN_H=2, FRAME_W=64, BASE_ADDR=0
    logic        s_start = 1'b0, s_ready = 1'b0;
    logic [15:0] s_win_x = '0, s_win_y = '0;
    logic        s_busy, s_done, s_mem_en, s_valid, s_last;
    logic [31:0] s_addr;
    logic [63:0] s_mem_data, s_data;
    logic [7:0]  s_row, s_col;

    assign s_mem_data = pat(s_addr);

    ref_fetch #(
        .FRAME_W   (64),
        .WIN_W     (16),
        .WIN_H     (2),
        .BASE_ADDR (32'h0)
    ) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (s_start),
        .win_x_i     (s_win_x),
        .win_y_i     (s_win_y),
        .busy_o      (s_busy),
        .done_o      (s_done),
        .mem_en_o    (s_mem_en),
        .mem_addr_o  (s_addr),
        .mem_data_i  (s_mem_data),
        .out_valid_o (s_valid),
        .out_ready_i (s_ready),
        .out_data_o  (s_data),
        .out_row_o   (s_row),
        .out_col_o   (s_col),
        .out_last_o  (s_last)
    );

    // Default-size instance with a base near the top of the address space.
    logic        d_start = 1'b0, d_ready = 1'b0;
    logic [15:0] d_win_x = '0, d_win_y = '0;
    logic        d_busy, d_done, d_mem_en, d_valid, d_last;
    logic [31:0] d_addr;
    logic [63:0] d_mem_data, d_data;
    logic [7:0]  d_row, d_col;

    assign d_mem_data = pat(d_addr);

    ref_fetch #(
        .BASE_ADDR (32'hFFFF_FF00)
    ) u_dflt (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (d_start),
        .win_x_i     (d_win_x),
        .win_y_i     (d_win_y),
        .busy_o      (d_busy),
        .done_o      (d_done),
        .mem_en_o    (d_mem_en),
        .mem_addr_o  (d_addr),
        .mem_data_i  (d_mem_data),
        .out_valid_o (d_valid),
        .out_ready_i (d_ready),
        .out_data_o  (d_data),
        .out_row_o   (d_row),
        .out_col_o   (d_col),
        .out_last_o  (d_last)
    );

    logic [31:0] exp_addr [4] = '{32'd200, 32'd208, 32'd264, 32'd272};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic check_small_zero(input string tag);
        check_eq({tag, "_busy"}, s_busy, 0);
        check_eq({tag, "_done"}, s_done, 0);
        check_eq({tag, "_mem_en"}, s_mem_en, 0);
        check_eq({tag, "_mem_addr"}, s_addr, 0);
        check_eq({tag, "_valid"}, s_valid, 0);
        check_eq({tag, "_data"}, s_data, 0);
        check_eq({tag, "_row"}, s_row, 0);
        check_eq({tag, "_col"}, s_col, 0);
        check_eq({tag, "_last"}, s_last, 0);
    endtask

    task automatic run_small(input int stall, input bit restart);
        int nrd = 0;
        int nwd = 0;
        int done_cyc = -1;
        int last_acc = -1;
        logic [63:0] held = '0;
        @(negedge clk);
        s_start = 1'b1;
        s_win_x = 16'd8;
        s_win_y = 16'd3;
        s_ready = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            s_start = restart && (cyc == 4);
            if (s_start) begin
                s_win_x = 16'd40;
                s_win_y = 16'd9;
            end
            s_ready = !(stall > 0 && cyc >= 2 && cyc < 2 + stall);
            #1;
            if (cyc == 1) check_eq("busy_after_start", s_busy, 1);
            if (cyc == 2) check_eq("first_valid_latency", s_valid, 1);
            if (s_mem_en) begin
                if (nrd < 4) check_eq("rd_addr", s_addr, exp_addr[nrd]);
                nrd++;
            end else begin
                check_eq("idle_addr_zero", s_addr, 0);
            end
            if (stall > 0 && cyc == 2) held = s_data;
            if (stall > 0 && cyc > 2 && cyc < 2 + stall) check_eq("held_data", s_data, held);
            if (stall > 0 && cyc == 1 + stall) check_eq("reads_during_stall", nrd, 2);
            if (s_valid && s_ready) begin
                if (nwd < 4) begin
                    check_eq("word_data", s_data, pat(exp_addr[nwd]));
                    check_eq("word_row", s_row, nwd / 2);
                    check_eq("word_col", s_col, nwd % 2);
                    check_eq("word_last", s_last, nwd == 3);
                end
                nwd++;
                last_acc = cyc;
            end
            if (s_done) begin
                if (done_cyc < 0) done_cyc = cyc;
                check_eq("busy_low_at_done", s_busy, 0);
            end
        end
        check_eq("read_count", nrd, 4);
        check_eq("word_count", nwd, 4);
        check_eq("done_cycle", done_cyc, 6 + stall);
        check_eq("done_after_last", done_cyc, last_acc + 1);
        check_eq("idle_valid_after", s_valid, 0);
        check_eq("idle_busy_after", s_busy, 0);
    endtask

    task automatic run_reset_mid;
        @(negedge clk);
        s_start = 1'b1;
        s_win_x = 16'd8;
        s_win_y = 16'd3;
        s_ready = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            s_start = 1'b0;
        end
        #1;
        check_eq("pre_reset_valid", s_valid, 1);
        check_eq("pre_reset_col", s_col, 0);
        rst_n = 1'b0;
        #1;
        check_small_zero("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            #1;
            check_eq("post_reset_valid", s_valid, 0);
            check_eq("post_reset_busy", s_busy, 0);
            check_eq("post_reset_mem_en", s_mem_en, 0);
        end
    endtask

    function automatic logic [31:0] dflt_addr(input int k);
        return 32'hFFFF_FF00 + (32'h0000_FFFF + 32'(k / 6)) * 32'd1920 + 32'd16
             + 32'(8 * (k % 6));
    endfunction

    task automatic run_default;
        int nrd = 0;
        int nwd = 0;
        int done_cyc = -1;
        @(negedge clk);
        d_start = 1'b1;
        d_win_x = 16'd16;
        d_win_y = 16'hFFFF;
        d_ready = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            d_start = 1'b0;
            #1;
            if (d_mem_en) begin
                if (nrd == 0) check_eq("wrap_first_addr", d_addr, 32'h077F_F790);
                check_eq("wrap_addr", d_addr, dflt_addr(nrd));
                nrd++;
            end
            if (d_valid) begin
                check_eq("dflt_word_cycle", cyc, nwd + 2);
                check_eq("dflt_word_data", d_data, pat(dflt_addr(nwd)));
                check_eq("dflt_word_last", d_last, nwd == 287);
                nwd++;
            end
            if (d_done && done_cyc < 0) done_cyc = cyc;
        end
        check_eq("dflt_read_count", nrd, 288);
        check_eq("dflt_word_count", nwd, 288);
        check_eq("dflt_done_cycle", done_cyc, 290);
        check_eq("dflt_busy_after", d_busy, 0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        #1;
        check_small_zero("reset");
        check_eq("reset_dflt_busy", d_busy, 0);
        check_eq("reset_dflt_valid", d_valid, 0);
        rst_n = 1'b1;
        run_small(0, 1'b0);
        run_small(5, 1'b0);
        run_small(0, 1'b1);
        run_reset_mid();
        run_small(0, 1'b0);
        run_default();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
